// File: rtl/kb_scancode_ctrl.sv
// PS/2 set-2 scancode sequencer: strips break/extended prefixes, tracks
// Shift/CapsLock and hands one make-code at a time to the ASCII converter.
module kb_scancode_ctrl #(
    parameter int TIMEOUT = 2048,
    parameter int TW      = 11
) (
    input  logic       clk,
    input  logic       i_sclr_n,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    input  logic       i_ready,
    output logic [7:0] o_scancode,
    output logic       o_shift,
    output logic       o_capslock,
    output logic       o_valid,
    output logic       o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          lsh_q, lsh_d;
    logic          rsh_q, rsh_d;
    logic          caps_q, caps_d;
    logic          caps_held_q, caps_held_d;
    logic [7:0]    code_q, code_d;
    logic          shift_q, shift_d;
    logic          capsout_q, capsout_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          make;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lsh_d       = lsh_q;
        rsh_d       = rsh_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        code_d      = code_q;
        shift_d     = shift_q;
        capsout_d   = capsout_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        make        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_byte_valid) begin
                    case (i_byte)
                        8'hF0: state_d = S_BRK;
                        8'hE0: state_d = S_EXT;
                        8'hE1, 8'h00, 8'hAA, 8'hEE,
                        8'hFA, 8'hFE, 8'hFF: ;
                        8'h12: lsh_d = 1'b1;
                        8'h59: rsh_d = 1'b1;
                        8'h58: begin
                            // held flag swallows typematic repeats of CapsLock
                            if (!caps_held_q) begin
                                caps_d      = ~caps_q;
                                caps_held_d = 1'b1;
                            end
                        end
                        default: make = 1'b1;
                    endcase
                end
            end
            S_BRK: begin
                if (i_byte_valid) begin
                    case (i_byte)
                        8'h12:   lsh_d = 1'b0;
                        8'h59:   rsh_d = 1'b0;
                        8'h58:   caps_held_d = 1'b0;
                        default: ;
                    endcase
                    state_d = S_IDLE;
                end
            end
            S_EXT: begin
                if (i_byte_valid) begin
                    state_d = (i_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
                end
            end
            default: begin
                if (i_byte_valid) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // a stalled prefix is abandoned after TIMEOUT quiet cycles
        if (state_q != S_IDLE) begin
            if (i_byte_valid) begin
                cnt_d = '0;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (make) begin
            if (!valid_q || i_ready) begin
                code_d    = i_byte;
                shift_d   = lsh_q | rsh_q;
                capsout_d = caps_q;
                valid_d   = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lsh_q       <= 1'b0;
            rsh_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            code_q      <= 8'h00;
            shift_q     <= 1'b0;
            capsout_q   <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lsh_q       <= lsh_d;
            rsh_q       <= rsh_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            code_q      <= code_d;
            shift_q     <= shift_d;
            capsout_q   <= capsout_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_scancode = code_q;
    assign o_shift    = shift_q;
    assign o_capslock = capsout_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;

endmodule

// File: doc/kb_scancode_ctrl.md
# kb_scancode_ctrl

Sequencer in front of the scancode-to-ASCII converter. Consumes the raw PS/2 set-2 byte stream from the receiver, decodes the F0 break and E0 extended prefixes, tracks the Shift and CapsLock modifier state, and presents one make-code at a time, with a modifier snapshot, over a valid/ready handshake. The converter's `i_scancode`, `i_shift` and `i_capslock` inputs are fed from this block's `o_scancode`, `o_shift` and `o_capslock` outputs, so the converter only ever sees plain, non-modifier make-codes.

## Interface
- `TIMEOUT`, default 2048: cycles without a byte, while a prefix is pending, before the FSM abandons it and returns to IDLE. Minimum 2.
- `TW`, default 11: timeout counter width. Requires 2^TW ≥ TIMEOUT.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `i_sclr_n`  in  1  synchronous, active-low reset.
- `i_byte`  in  8  received PS/2 byte.
- `i_byte_valid`  in  1  one-cycle strobe; `i_byte` is valid in that cycle.
- `i_ready`  in  1  downstream accepts the key in this cycle.
- `o_scancode`  out  8  held make-code.
- `o_shift`  out  1  (left Shift OR right Shift), captured when the key was loaded.
- `o_capslock`  out  1  CapsLock toggle state, captured when the key was loaded.
- `o_valid`  out  1  key held, awaiting transfer.
- `o_overflow`  out  1  sticky flag: a key was dropped.

## Operation
- **Reset** (`i_sclr_n` = 0 at an edge):
  - state = IDLE.
  - `o_scancode` = 00; `o_shift`, `o_capslock`, `o_valid`, `o_overflow` = 0.
  - Internal `lsh`, `rsh`, `caps`, `caps_held` = 0; timeout counter = 0.
  - Reset overrides every other event in the same cycle.
- **FSM states:** IDLE, BRK, EXT, EXT_BRK. Transitions occur only on `i_byte_valid` or on timeout.
- **IDLE:**
  - F0 → BRK.
  - E0 → EXT.
  - Discard without changing state: E1, 00, AA, EE, FA, FE, FF.
  - 12 → `lsh` = 1.
  - 59 → `rsh` = 1.
  - 58 → if `caps_held` = 0: `caps` toggles and `caps_held` = 1. If `caps_held` = 1, no change; this suppresses typematic repeat.
  - Any other byte is a key make-code; it goes to the key load below.
- **BRK:**
  - 12 → `lsh` = 0.
  - 59 → `rsh` = 0.
  - 58 → `caps_held` = 0.
  - F0 or E0 → protocol error: byte discarded, no modifier change.
  - All other bytes discarded.
  - Always → IDLE.
- **EXT:**
  - F0 → EXT_BRK.
  - Any other byte (extended make, including fake-shift E0 12) discarded → IDLE.
- **EXT_BRK:** any byte discarded → IDLE. Extended keys never reach the converter and never alter modifiers.
- **Key load** (IDLE make-code):
  - If `o_valid` = 0, or `o_valid` and `i_ready` are both 1 in the same cycle: `o_scancode` = byte, `o_shift` = `lsh`|`rsh`, `o_capslock` = `caps`, `o_valid` = 1.
  - Otherwise the key is dropped and `o_overflow` = 1.
- **Modifier snapshot:** the snapshot uses modifier values before the current byte's update. Only modifier bytes change modifiers, and modifier bytes never load, so no conflict arises.
- **Transfer:** `o_valid` and `i_ready` both 1 at an edge with no load → `o_valid` = 0. `o_scancode` keeps its last value.
- **`o_overflow`:** cleared only by reset.
- **Timeout counter:**
  - Cleared in IDLE and on every `i_byte_valid`.
  - Otherwise increments each cycle while in BRK, EXT or EXT_BRK.
  - When it equals TIMEOUT−1 with no byte in that cycle → IDLE and counter = 0. Modifiers are unchanged.

## Timing
- A byte strobe at edge N gives registered state and outputs after edge N.
- Key latency: `o_valid` rises 1 cycle after the make-code strobe.
- `o_valid` stays high, with the data stable, until the edge where `i_ready` = 1. `i_ready` may be high continuously, giving one key per byte strobe with no bubble.
- Modifier update: visible to a make-code strobed on any later cycle, including N+1.
- No combinational path from inputs to outputs.

## Test plan
- **Basic make:** reset, then byte 1C with `i_ready` = 1 → `o_valid` = 1 one cycle later, `o_scancode` = 1C, `o_shift` = 0, `o_capslock` = 0. `o_valid` is 0 the following cycle.
- **Shift:** bytes 12, 1C, F0 1C, F0 12, 1C → keys 1C/shift=1, then 1C/shift=0. Break codes produce no key. Repeat using 59 for the right Shift.
- **CapsLock:**
  - Bytes 58, 58, 58, F0 58, 1C → exactly one toggle; key 1C with `o_capslock` = 1.
  - Then 58, F0 58, 1C → 1C with `o_capslock` = 0.
- **Extended keys:** bytes E0 75, E0 F0 75, E0 12, 2D → only key 2D emitted, with `o_shift` = 0.
- **Backpressure:** `i_ready` = 0; bytes 1C then 32 → `o_scancode` stays 1C and `o_overflow` = 1.
  - Separately, with key 1C held, raise `i_ready` in the same cycle as strobe 32 → 32 loads, `o_valid` remains 1, `o_overflow` stays 0.
- **Timeout and reset:**
  - Byte F0, then idle TIMEOUT cycles, then 12 → `lsh` set, i.e. a later 1C carries `o_shift` = 1.
  - Asserting `i_sclr_n` = 0 while in EXT_BRK with `o_valid` = 1 → all outputs 0 on the next cycle, FSM in IDLE.
